// File: rtl/pingpong_frame_scheduler_pkg.sv
// Shared types and helpers for the ping-pong frame scheduler.
// Optional feature macro used by this slice: FRAME_TIMEOUT_EN (stall timeout + FLUSH).
package pingpong_frame_scheduler_pkg;

  // Number of frame consumers sharing the buffer read side.
  localparam int N_REQ = 2;

  // Scheduler states; FLUSH is only reachable when FRAME_TIMEOUT_EN is defined.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } sched_state_t;

  // Consumer index to one-hot grant vector.
  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  // Saturating increment for the 8-bit dropped-frame counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/pingpong_frame_scheduler_if.sv
// Bundle of buffer read-port and consumer handshake signals.
// Signal suffixes are from the scheduler's point of view: the scheduler uses
// the slave modport, the surrounding system (buffer + consumers) uses master.
interface pingpong_frame_scheduler_if
  import pingpong_frame_scheduler_pkg::*;
#(
  parameter int WIDTH = 32
);

  logic                    buf_ready_i;
  logic signed [WIDTH-1:0] rd_data_i;
  logic                    rd_valid_i;
  logic                    rd_ready_o;
  logic [N_REQ-1:0]        req_i;
  logic [N_REQ-1:0]        grant_o;
  logic signed [WIDTH-1:0] data_o;
  logic [N_REQ-1:0]        valid_o;
  logic [N_REQ-1:0]        ready_i;
  logic                    last_o;

  modport master (
    output buf_ready_i, rd_data_i, rd_valid_i, req_i, ready_i,
    input  rd_ready_o, grant_o, data_o, valid_o, last_o
  );

  modport slave (
    input  buf_ready_i, rd_data_i, rd_valid_i, req_i, ready_i,
    output rd_ready_o, grant_o, data_o, valid_o, last_o
  );

endinterface

// File: rtl/pingpong_frame_scheduler_rr_arbiter2.sv
// Two-way round-robin pick. rr_i holds the index of the previous winner;
// on a tie the other consumer wins, otherwise the single requester wins.
module rr_arbiter2
  import pingpong_frame_scheduler_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic             rr_i,
  output logic             any_o,
  output logic             winner_o
);

  // Combinational winner selection.
  always_comb begin
    any_o    = |req_i;
    winner_o = 1'b0;
    if (&req_i) begin
      winner_o = ~rr_i;
    end else if (req_i[1]) begin
      winner_o = 1'b1;
    end
  end

endmodule

// File: rtl/pingpong_frame_scheduler.sv
// Read-side sequencer for the ping-pong frame buffer. On each swap pulse a
// whole frame of DEPTH beats is granted round-robin to one of two consumers
// and forwarded with zero latency, with last-beat marking, drop counting and
// overrun detection.
// Optional feature macro: FRAME_TIMEOUT_EN adds a stall timeout that flushes
// the rest of a frame when the owning consumer stops accepting data.
module pingpong_frame_scheduler
  import pingpong_frame_scheduler_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int TIMEOUT    = 1024
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  pingpong_frame_scheduler_if.slave  bus,
  output logic                       busy_o,
  output logic [7:0]                 drop_count_o,
  output logic                       overrun_o,
  output logic                       timeout_o
);

  localparam logic [ADDR_WIDTH:0] LAST_BEAT = (ADDR_WIDTH+1)'(DEPTH - 1);

  sched_state_t          state_q, state_d;
  logic [ADDR_WIDTH:0]   beat_cnt_q, beat_cnt_d;
  logic                  rr_q, rr_d;
  logic                  owner_q, owner_d;
  logic [7:0]            drop_q, drop_d;
  logic                  overrun_q, overrun_d;

  logic                  arb_any;
  logic                  arb_winner;
  logic                  start_arb;
  logic                  owner_ready;
  logic                  beat;
  logic                  at_last;
  logic signed [WIDTH-1:0] fwd_data;

`ifdef FRAME_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT + 1);
  localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(TIMEOUT - 1);

  logic [STALL_W-1:0]    stall_q, stall_d;
  logic                  timeout_q, timeout_d;
  logic                  stall;
`else
  localparam int unused_timeout = TIMEOUT;
`endif

  rr_arbiter2 u_arb (
    .req_i    (bus.req_i),
    .rr_i     (rr_q),
    .any_o    (arb_any),
    .winner_o (arb_winner)
  );

  assign owner_ready = bus.ready_i[owner_q];
  assign beat        = bus.rd_valid_i & owner_ready;
  assign at_last     = (beat_cnt_q == LAST_BEAT);
  assign fwd_data    = bus.rd_data_i;

`ifdef FRAME_TIMEOUT_EN
  assign stall = bus.rd_valid_i & ~owner_ready;
`endif

  // State register plus all counters and sticky flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      rr_q       <= 1'b1;
      owner_q    <= 1'b0;
      drop_q     <= '0;
      overrun_q  <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
      stall_q    <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      rr_q       <= rr_d;
      owner_q    <= owner_d;
      drop_q     <= drop_d;
      overrun_q  <= overrun_d;
`ifdef FRAME_TIMEOUT_EN
      stall_q    <= stall_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  // Next-state logic: frame progress, swap handling and arbitration.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    rr_d       = rr_q;
    owner_d    = owner_q;
    drop_d     = drop_q;
    overrun_d  = overrun_q;
    start_arb  = 1'b0;
`ifdef FRAME_TIMEOUT_EN
    stall_d    = stall_q;
    timeout_d  = timeout_q;
`endif

    case (state_q)
      IDLE: begin
        start_arb = bus.buf_ready_i;
      end

      STREAM: begin
        if (beat && at_last) begin
          // Frame complete; a swap in this same cycle is a fresh frame, not an overrun.
          state_d    = IDLE;
          beat_cnt_d = '0;
          start_arb  = bus.buf_ready_i;
        end else if (bus.buf_ready_i) begin
          // Buffer restarted under us: keep the owner, restart from beat 0.
          overrun_d  = 1'b1;
          beat_cnt_d = '0;
        end else if (beat) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
`ifdef FRAME_TIMEOUT_EN
        if (beat) begin
          stall_d = '0;
        end else if (stall) begin
          if (stall_q >= STALL_LIMIT) begin
            if (!bus.buf_ready_i) begin
              timeout_d = 1'b1;
              stall_d   = '0;
              state_d   = FLUSH;
            end
          end else begin
            stall_d = stall_q + 1'b1;
          end
        end
`endif
      end

      default: begin
`ifdef FRAME_TIMEOUT_EN
        // Drain and discard what is left of the stalled frame.
        if (bus.buf_ready_i) begin
          drop_d     = sat_inc8(drop_q);
          state_d    = IDLE;
          beat_cnt_d = '0;
        end else if (bus.rd_valid_i) begin
          if (at_last) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
`else
        state_d = IDLE;
`endif
      end
    endcase

    if (start_arb) begin
      if (arb_any) begin
        state_d    = STREAM;
        owner_d    = arb_winner;
        rr_d       = arb_winner;
        beat_cnt_d = '0;
`ifdef FRAME_TIMEOUT_EN
        stall_d    = '0;
`endif
      end else begin
        drop_d = sat_inc8(drop_q);
      end
    end
  end

  // Output decode: forwarding and handshakes depend only on state and live inputs.
  always_comb begin
    bus.grant_o    = '0;
    bus.valid_o    = '0;
    bus.rd_ready_o = 1'b0;
    bus.data_o     = '0;
    bus.last_o     = 1'b0;
    busy_o         = 1'b0;
    case (state_q)
      STREAM: begin
        bus.grant_o    = idx_to_onehot(owner_q);
        bus.valid_o    = bus.rd_valid_i ? idx_to_onehot(owner_q) : '0;
        bus.rd_ready_o = owner_ready;
        bus.data_o     = fwd_data;
        bus.last_o     = at_last & bus.rd_valid_i;
        busy_o         = 1'b1;
      end
      FLUSH: begin
        bus.rd_ready_o = 1'b1;
        busy_o         = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign drop_count_o = drop_q;
  assign overrun_o    = overrun_q;
`ifdef FRAME_TIMEOUT_EN
  assign timeout_o    = timeout_q;
`else
  assign timeout_o    = 1'b0;
`endif

endmodule

// File: tb/tb_pingpong_frame_scheduler.sv
// Directed bench for pingpong_frame_scheduler with DEPTH=8, TIMEOUT=16.
// The timeout/flush scenario only runs when FRAME_TIMEOUT_EN is defined.
module tb_pingpong_frame_scheduler;

  localparam int WIDTH   = 32;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 16;

  logic       clk;
  logic       rst;
  logic       busy;
  logic [7:0] dropCount;
  logic       overrun;
  logic       timeoutFlag;

  int nChecks = 0;
  int nFail   = 0;

  logic [1:0] curReq;
  logic [1:0] curReady;

  pingpong_frame_scheduler_if #(.WIDTH(WIDTH)) ifc ();

  pingpong_frame_scheduler #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .bus          (ifc.slave),
    .busy_o       (busy),
    .drop_count_o (dropCount),
    .overrun_o    (overrun),
    .timeout_o    (timeoutFlag)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive all DUT inputs, then let combinational outputs settle.
  task automatic applyStimulus(input logic bufReady, input logic [1:0] req,
                               input logic rdValid, input logic [1:0] ready,
                               input logic [31:0] rdData);
    ifc.buf_ready_i = bufReady;
    ifc.req_i       = req;
    ifc.rd_valid_i  = rdValid;
    ifc.ready_i     = ready;
    ifc.rd_data_i   = rdData;
    #1;
  endtask

  // Advance one clock and sample just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One comparison point.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nChecks++;
    assert (observed === expected)
    else begin
      nFail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Stream beats firstBeat..firstBeat+nBeats-1 with both data and handshake checks.
  task automatic runBeats(input string tag, input logic [1:0] grantExp,
                          input int firstBeat, input int nBeats);
    for (int i = 0; i < nBeats; i++) begin
      applyStimulus(1'b0, curReq, 1'b1, curReady, 32'hA000 + 32'(firstBeat + i));
      checkOutput({tag, "_grant"}, 32'(ifc.grant_o), 32'(grantExp));
      checkOutput({tag, "_valid"}, 32'(ifc.valid_o), 32'(grantExp));
      checkOutput({tag, "_data"},  ifc.data_o, 32'hA000 + 32'(firstBeat + i));
      checkOutput({tag, "_last"},  32'(ifc.last_o), ((firstBeat + i) == DEPTH - 1) ? 32'd1 : 32'd0);
      tick();
    end
  endtask

  initial begin
    $display("[TB] starting directed test, DEPTH=%0d", DEPTH);
    curReq   = 2'b00;
    curReady = 2'b11;
    rst      = 1'b1;
    applyStimulus(1'b0, 2'b00, 1'b0, 2'b00, 32'h0);
    tick();
    tick();

    // Reset values.
    checkOutput("rst_grant",   32'(ifc.grant_o),    32'd0);
    checkOutput("rst_valid",   32'(ifc.valid_o),    32'd0);
    checkOutput("rst_rdready", 32'(ifc.rd_ready_o), 32'd0);
    checkOutput("rst_busy",    32'(busy),           32'd0);
    checkOutput("rst_drop",    32'(dropCount),      32'd0);
    checkOutput("rst_overrun", 32'(overrun),        32'd0);
    checkOutput("rst_timeout", 32'(timeoutFlag),    32'd0);
    rst = 1'b0;

    // 1: single requester, full frame on consumer 0.
    curReq = 2'b01; curReady = 2'b11;
    applyStimulus(1'b1, curReq, 1'b1, curReady, 32'h0);
    checkOutput("t1_idle_grant", 32'(ifc.grant_o), 32'd0);
    tick();
    applyStimulus(1'b0, curReq, 1'b1, curReady, 32'h0);
    checkOutput("t1_rdready", 32'(ifc.rd_ready_o), 32'd1);
    checkOutput("t1_busy",    32'(busy),           32'd1);
    runBeats("t1", 2'b01, 0, DEPTH);
    applyStimulus(1'b0, curReq, 1'b1, curReady, 32'h0);
    checkOutput("t1_end_grant", 32'(ifc.grant_o), 32'd0);
    checkOutput("t1_end_valid", 32'(ifc.valid_o), 32'd0);
    checkOutput("t1_end_busy",  32'(busy),        32'd0);

    // 2: both requesting; swap coincident with last beat is a new frame, not an overrun.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    curReq = 2'b11; curReady = 2'b11;
    applyStimulus(1'b1, curReq, 1'b1, curReady, 32'h0);
    tick();
    runBeats("t2a", 2'b01, 0, DEPTH - 1);
    applyStimulus(1'b1, curReq, 1'b1, curReady, 32'hA007);
    checkOutput("t2_coinc_last", 32'(ifc.last_o), 32'd1);
    tick();
    applyStimulus(1'b0, curReq, 1'b1, curReady, 32'h0);
    checkOutput("t2_new_grant", 32'(ifc.grant_o), 32'b10);
    checkOutput("t2_no_overrun", 32'(overrun), 32'd0);
    curReady = 2'b10;
    applyStimulus(1'b0, curReq, 1'b1, curReady, 32'h0);
    checkOutput("t2_rdready_c1", 32'(ifc.rd_ready_o), 32'd1);
    runBeats("t2b", 2'b10, 0, DEPTH);
    curReady = 2'b11;
    applyStimulus(1'b1, curReq, 1'b1, curReady, 32'h0);
    tick();
    applyStimulus(1'b0, curReq, 1'b1, curReady, 32'h0);
    checkOutput("t2_third_grant", 32'(ifc.grant_o), 32'b01);
    runBeats("t2c", 2'b01, 0, DEPTH);

    // 3: swaps with no requester are dropped and the count saturates.
    curReq = 2'b00;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, curReq, 1'b0, curReady, 32'h0);
      tick();
      applyStimulus(1'b0, curReq, 1'b0, curReady, 32'h0);
      tick();
    end
    checkOutput("t3_drop3", 32'(dropCount), 32'd3);
    checkOutput("t3_grant", 32'(ifc.grant_o), 32'd0);
    applyStimulus(1'b1, curReq, 1'b0, curReady, 32'h0);
    for (int i = 0; i < 260; i++) tick();
    applyStimulus(1'b0, curReq, 1'b0, curReady, 32'h0);
    checkOutput("t3_drop_sat", 32'(dropCount), 32'd255);
    checkOutput("t3_busy", 32'(busy), 32'd0);

    // 4: swap at beat 4 is an overrun; frame restarts for the same owner.
    curReq = 2'b01; curReady = 2'b11;
    applyStimulus(1'b1, curReq, 1'b1, curReady, 32'h0);
    tick();
    runBeats("t4a", 2'b01, 0, 4);
    applyStimulus(1'b1, curReq, 1'b1, curReady, 32'h0);
    checkOutput("t4_pre_overrun", 32'(overrun), 32'd0);
    tick();
    applyStimulus(1'b0, curReq, 1'b1, curReady, 32'h0);
    checkOutput("t4_overrun", 32'(overrun), 32'd1);
    checkOutput("t4_grant_held", 32'(ifc.grant_o), 32'b01);
    runBeats("t4b", 2'b01, 0, 3);
    applyStimulus(1'b0, curReq, 1'b0, curReady, 32'h0);
    checkOutput("t4_novalid_valid", 32'(ifc.valid_o), 32'd0);
    checkOutput("t4_novalid_last",  32'(ifc.last_o),  32'd0);
    tick();
    runBeats("t4c", 2'b01, 3, 4);
    curReady = 2'b10;
    applyStimulus(1'b0, curReq, 1'b1, curReady, 32'hA007);
    checkOutput("t4_stall_last",    32'(ifc.last_o),     32'd1);
    checkOutput("t4_stall_rdready", 32'(ifc.rd_ready_o), 32'd0);
    tick();
    applyStimulus(1'b0, curReq, 1'b1, curReady, 32'hA007);
    checkOutput("t4_stall_grant", 32'(ifc.grant_o), 32'b01);
    curReady = 2'b11;
    runBeats("t4d", 2'b01, 7, 1);
    applyStimulus(1'b0, curReq, 1'b1, curReady, 32'h0);
    checkOutput("t4_end_grant", 32'(ifc.grant_o), 32'd0);

`ifdef FRAME_TIMEOUT_EN
    // 5: consumer 0 stalls for TIMEOUT cycles, frame is flushed.
    curReq = 2'b01; curReady = 2'b11;
    applyStimulus(1'b1, curReq, 1'b1, curReady, 32'h0);
    tick();
    runBeats("t5a", 2'b01, 0, 2);
    curReady = 2'b00;
    applyStimulus(1'b0, curReq, 1'b1, curReady, 32'h0);
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    checkOutput("t5_pre_grant",   32'(ifc.grant_o), 32'b01);
    checkOutput("t5_pre_timeout", 32'(timeoutFlag), 32'd0);
    tick();
    checkOutput("t5_timeout", 32'(timeoutFlag),    32'd1);
    checkOutput("t5_grant",   32'(ifc.grant_o),    32'd0);
    checkOutput("t5_valid",   32'(ifc.valid_o),    32'd0);
    checkOutput("t5_rdready", 32'(ifc.rd_ready_o), 32'd1);
    for (int i = 0; i < DEPTH - 3; i++) tick();
    checkOutput("t5_flush_busy", 32'(busy), 32'd1);
    tick();
    checkOutput("t5_idle_busy",    32'(busy),           32'd0);
    checkOutput("t5_idle_rdready", 32'(ifc.rd_ready_o), 32'd0);
`endif

    // 6: reset mid-frame abandons it; next swap grants consumer 0 from beat 0.
    curReq = 2'b01; curReady = 2'b11;
    applyStimulus(1'b1, curReq, 1'b1, curReady, 32'h0);
    tick();
    runBeats("t6a", 2'b01, 0, 3);
    rst = 1'b1;
    applyStimulus(1'b0, curReq, 1'b1, curReady, 32'h5555);
    tick();
    checkOutput("t6_grant",   32'(ifc.grant_o),    32'd0);
    checkOutput("t6_valid",   32'(ifc.valid_o),    32'd0);
    checkOutput("t6_rdready", 32'(ifc.rd_ready_o), 32'd0);
    checkOutput("t6_data",    ifc.data_o,          32'd0);
    checkOutput("t6_busy",    32'(busy),           32'd0);
    checkOutput("t6_drop",    32'(dropCount),      32'd0);
    checkOutput("t6_overrun", 32'(overrun),        32'd0);
    rst = 1'b0;
    curReq = 2'b11;
    applyStimulus(1'b1, curReq, 1'b1, curReady, 32'h0);
    tick();
    runBeats("t6b", 2'b01, 0, DEPTH);
    applyStimulus(1'b0, curReq, 1'b0, curReady, 32'h0);
    checkOutput("t6_end_grant", 32'(ifc.grant_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
